// File: rtl/set_max_n.sv
// Editable BCD limit register: direct load from set_val, or digit-by-digit edit with up/down/select
// buttons, accepted on commit. max_val is the active limit and edit_val is the shadow copy under edit.
module set_max_n #(
    parameter int unsigned NDIG = 2,
    parameter logic [4*NDIG-1:0] DEF_MAX = {NDIG{4'h9}}
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic                    EN_work,
    input  logic                    EN_set,
    input  logic                    load_n,
    input  logic [4*NDIG-1:0]       set_val,
    input  logic                    btn_sel,
    input  logic                    btn_up,
    input  logic                    btn_dn,
    input  logic                    commit,
    output logic [4*NDIG-1:0]       max_val,
    output logic [4*NDIG-1:0]       edit_val,
    output logic [((NDIG > 1) ? $clog2(NDIG) : 1)-1:0] edit_dig,
    output logic                    editing,
    output logic                    max_upd
);

    localparam int unsigned DW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {StIdle, StEdit, StLock} state_e;

    state_e            state_q, state_d;
    logic [4*NDIG-1:0] max_q, max_d;
    logic [4*NDIG-1:0] edit_q, edit_d;
    logic [DW-1:0]     dig_q, dig_d;
    logic              upd_q, upd_d;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Modulo-10 step of a single digit; up and down together cancel.
    function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic up, input logic dn);
        logic [3:0] r;
        r = d;
        if (up && !dn) begin
            r = (d >= 4'd9) ? 4'd0 : d + 4'd1;
        end else if (dn && !up) begin
            r = (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        edit_d  = edit_q;
        dig_d   = dig_q;
        upd_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (EN_work && EN_set) begin
                    state_d = StEdit;
                    edit_d  = max_q;
                    dig_d   = '0;
                end else if (EN_work && !load_n) begin
                    for (int i = 0; i < NDIG; i++) begin
                        max_d[4*i +: 4] = bcd_clamp(set_val[4*i +: 4]);
                    end
                    upd_d = 1'b1;
                end
            end
            StEdit: begin
                // Leaving edit mode discards the edit and outranks commit.
                if (!EN_set || !EN_work) begin
                    state_d = StIdle;
                end else if (commit) begin
                    state_d = StLock;
                    max_d   = edit_q;
                    upd_d   = 1'b1;
                end else begin
                    for (int i = 0; i < NDIG; i++) begin
                        if (DW'(i) == dig_q) begin
                            edit_d[4*i +: 4] = bcd_step(edit_q[4*i +: 4], btn_up, btn_dn);
                        end
                    end
                    if (btn_sel) begin
                        dig_d = (dig_q == DW'(NDIG - 1)) ? '0 : dig_q + 1'b1;
                    end
                end
            end
            StLock: begin
                if (!EN_set || !EN_work) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= StIdle;
            max_q   <= DEF_MAX;
            edit_q  <= DEF_MAX;
            dig_q   <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            edit_q  <= edit_d;
            dig_q   <= dig_d;
            upd_q   <= upd_d;
        end
    end

    assign max_val  = max_q;
    assign edit_val = edit_q;
    assign edit_dig = dig_q;
    assign editing  = (state_q == StEdit);
    assign max_upd  = upd_q;

endmodule

// File: tb/tb_set_max_n.sv
// Directed bench for set_max_n: limit updates are predicted into a queue and checked by a monitor
// that pops on every max_upd pulse; edit-state outputs are checked after each stimulus step.
module tb_set_max_n;

    logic       CLK;
    logic       RST_n;
    logic       EN_work, EN_set, load_n, btn_sel, btn_up, btn_dn, commit;
    logic [7:0] set_val;
    logic [7:0] max_val, edit_val;
    logic [0:0] edit_dig;
    logic       editing, max_upd;

    logic        en_set3, sel3;
    logic [11:0] max_val3, edit_val3;
    logic [1:0]  edit_dig3;
    logic        editing3, max_upd3;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    set_max_n #(.NDIG(2), .DEF_MAX(8'h99)) dut (
        .CLK(CLK), .RST_n(RST_n), .EN_work(EN_work), .EN_set(EN_set), .load_n(load_n),
        .set_val(set_val), .btn_sel(btn_sel), .btn_up(btn_up), .btn_dn(btn_dn), .commit(commit),
        .max_val(max_val), .edit_val(edit_val), .edit_dig(edit_dig), .editing(editing),
        .max_upd(max_upd)
    );

    set_max_n #(.NDIG(3), .DEF_MAX(12'h999)) dut3 (
        .CLK(CLK), .RST_n(RST_n), .EN_work(1'b1), .EN_set(en_set3), .load_n(1'b1),
        .set_val(12'h000), .btn_sel(sel3), .btn_up(1'b0), .btn_dn(1'b0), .commit(1'b0),
        .max_val(max_val3), .edit_val(edit_val3), .edit_dig(edit_dig3), .editing(editing3),
        .max_upd(max_upd3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RST_n && max_upd) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL upd_unexpected: got max_upd=1 max_val=%h, expected no update", max_val);
            end else begin
                chk("upd_max_val", {24'h0, max_val}, {24'h0, exp_q.pop_front()});
            end
        end
        if (RST_n && max_upd3) begin
            total++;
            bad++;
            $display("FAIL upd3_unexpected: got max_upd=1, expected 0");
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic up_n(input int n);
        repeat (n) begin btn_up = 1'b1; tick(); btn_up = 1'b0; end
    endtask

    task automatic dn_n(input int n);
        repeat (n) begin btn_dn = 1'b1; tick(); btn_dn = 1'b0; end
    endtask

    task automatic sel_n(input int n);
        repeat (n) begin btn_sel = 1'b1; tick(); btn_sel = 1'b0; end
    endtask

    task automatic load(input logic [7:0] v, input logic [7:0] expv);
        set_val = v;
        load_n  = 1'b0;
        exp_q.push_back(expv);
        tick();
        load_n  = 1'b1;
        chk("load_max_val", {24'h0, max_val}, {24'h0, expv});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        RST_n = 1'b0; EN_work = 1'b0; EN_set = 1'b0; load_n = 1'b1; set_val = 8'h00;
        btn_sel = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; commit = 1'b0;
        en_set3 = 1'b0; sel3 = 1'b0;
        #12 RST_n = 1'b1;
        tick();
        chk("rst_max_val", {24'h0, max_val}, 32'h99);
        chk("rst_edit_val", {24'h0, edit_val}, 32'h99);
        chk("rst_editing", {31'h0, editing}, 32'h0);

        // Direct load with clamping; disabled when EN_work is low.
        EN_work = 1'b1;
        load(8'hA3, 8'h93);
        EN_work = 1'b0; load_n = 1'b0; set_val = 8'h12;
        tick();
        load_n = 1'b1; EN_work = 1'b1;
        chk("load_no_work", {24'h0, max_val}, 32'h93);
        load(8'h5F, 8'h59);
        load(8'h99, 8'h99);

        // Edit flow and lock.
        EN_set = 1'b1;
        tick();
        chk("enter_editing", {31'h0, editing}, 32'h1);
        chk("enter_edit_val", {24'h0, edit_val}, 32'h99);
        chk("enter_edit_dig", {31'h0, edit_dig}, 32'h0);
        up_n(1);
        chk("up_wrap", {24'h0, edit_val}, 32'h90);
        sel_n(1);
        chk("sel_dig1", {31'h0, edit_dig}, 32'h1);
        dn_n(1);
        chk("dn_digit1", {24'h0, edit_val}, 32'h80);
        load_n = 1'b0; set_val = 8'h11;
        tick();
        load_n = 1'b1;
        chk("edit_ignores_load", {24'h0, max_val}, 32'h99);
        commit = 1'b1; exp_q.push_back(8'h80);
        tick();
        commit = 1'b0;
        chk("commit_max_val", {24'h0, max_val}, 32'h80);
        chk("commit_editing", {31'h0, editing}, 32'h0);
        up_n(1);
        tick();
        chk("lock_editing", {31'h0, editing}, 32'h0);
        chk("lock_edit_val", {24'h0, edit_val}, 32'h80);
        EN_set = 1'b0;
        tick();
        EN_set = 1'b1;
        tick();
        chk("reenter_editing", {31'h0, editing}, 32'h1);
        chk("reenter_edit_val", {24'h0, edit_val}, 32'h80);

        // Boundaries: up+dn cancel, dn from 0, sel coinciding with up, select wrap.
        btn_up = 1'b1; btn_dn = 1'b1;
        tick();
        btn_up = 1'b0; btn_dn = 1'b0;
        chk("updn_cancel", {24'h0, edit_val}, 32'h80);
        dn_n(1);
        chk("dn_wrap", {24'h0, edit_val}, 32'h89);
        btn_up = 1'b1; btn_sel = 1'b1;
        tick();
        btn_up = 1'b0; btn_sel = 1'b0;
        chk("sel_up_val", {24'h0, edit_val}, 32'h80);
        chk("sel_up_dig", {31'h0, edit_dig}, 32'h1);
        sel_n(1);
        chk("sel_wrap", {31'h0, edit_dig}, 32'h0);

        // Abort overrides commit.
        up_n(5); sel_n(1); dn_n(3);
        chk("abort_setup", {24'h0, edit_val}, 32'h55);
        EN_work = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("abort_editing", {31'h0, editing}, 32'h0);
        chk("abort_max_val", {24'h0, max_val}, 32'h80);

        // Commit outranks a simultaneous btn_up.
        EN_work = 1'b1;
        tick();
        up_n(2); sel_n(1); dn_n(4);
        chk("prio_setup", {24'h0, edit_val}, 32'h42);
        commit = 1'b1; btn_up = 1'b1; exp_q.push_back(8'h42);
        tick();
        commit = 1'b0; btn_up = 1'b0;
        chk("prio_max_val", {24'h0, max_val}, 32'h42);

        // Asynchronous reset mid-edit.
        EN_set = 1'b0;
        tick();
        EN_set = 1'b1;
        tick();
        up_n(1); sel_n(1);
        #2 RST_n = 1'b0;
        #1;
        chk("arst_max_val", {24'h0, max_val}, 32'h99);
        chk("arst_edit_val", {24'h0, edit_val}, 32'h99);
        chk("arst_editing", {31'h0, editing}, 32'h0);
        chk("arst_edit_dig", {31'h0, edit_dig}, 32'h0);
        chk("arst_max_upd", {31'h0, max_upd}, 32'h0);
        tick();
        #2 RST_n = 1'b1;
        tick();
        chk("post_rst_editing", {31'h0, editing}, 32'h1);
        chk("post_rst_edit_val", {24'h0, edit_val}, 32'h99);
        EN_set = 1'b0;

        // NDIG=3 select wrap.
        en_set3 = 1'b1;
        tick();
        chk("n3_editing", {31'h0, editing3}, 32'h1);
        chk("n3_dig0", {30'h0, edit_dig3}, 32'h0);
        sel3 = 1'b1; tick(); sel3 = 1'b0;
        chk("n3_dig1", {30'h0, edit_dig3}, 32'h1);
        sel3 = 1'b1; tick(); sel3 = 1'b0;
        chk("n3_dig2", {30'h0, edit_dig3}, 32'h2);
        sel3 = 1'b1; tick(); sel3 = 1'b0;
        chk("n3_dig_wrap", {30'h0, edit_dig3}, 32'h0);
        chk("n3_edit_val", {20'h0, edit_val3}, 32'h999);
        en_set3 = 1'b0;

        tick();
        tick();
        chk("queue_empty", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/set_max_n.md
SET_MAX_N -- requirements
Module: set_max_n

Interface
REQ-001 SHALL have parameter NDIG, default 2: number of BCD digits in the limit (NDIG >= 1).
REQ-002 SHALL have parameter DEF_MAX, width 4*NDIG, default all digits 9: reset limit value; every nibble SHALL be valid BCD (0-9).
REQ-003 SHALL have port CLK, input, 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port RST_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port EN_work, input, 1: system-working enable; low forbids any limit change.
REQ-006 SHALL have port EN_set, input, 1: edit-mode request, level.
REQ-007 SHALL have port load_n, input, 1: direct-load strobe, active-low.
REQ-008 SHALL have port set_val, input, 4*NDIG: direct-load BCD value, digit 0 in bits [3:0].
REQ-009 SHALL have ports btn_sel, btn_up and btn_dn, input, 1 each: single-cycle pulses for next digit, increment and decrement.
REQ-010 SHALL have port commit, input, 1: single-cycle pulse that accepts the edited value.
REQ-011 SHALL have port max_val, output, 4*NDIG: active limit, registered.
REQ-012 SHALL have port edit_val, output, 4*NDIG: shadow value under edit, registered.
REQ-013 SHALL have port edit_dig, output, max(1,clog2(NDIG)): index of the selected digit, registered.
REQ-014 SHALL have port editing, output, 1: high while the FSM is in EDIT.
REQ-015 SHALL have port max_upd, output, 1: one-cycle pulse, high in the same cycle max_val first shows a new value.

Function
REQ-016 SHALL implement an FSM with three states: IDLE, EDIT and LOCK.
REQ-017 IDLE -> EDIT SHALL occur when EN_work=1 and EN_set=1; on that edge edit_val <= max_val and edit_dig <= 0.
REQ-018 In IDLE with EN_work=1, EN_set=0 and load_n=0, max_val SHALL load set_val with each digit clamped (>9 -> 9), and max_upd SHALL pulse.
REQ-019 In EDIT, btn_up SHALL increment the selected digit modulo 10 (9 -> 0), with no carry into other digits.
REQ-020 In EDIT, btn_dn SHALL decrement the selected digit modulo 10 (0 -> 9), with no borrow from other digits.
REQ-021 btn_up and btn_dn asserted in the same cycle SHALL leave the digit unchanged.
REQ-022 In EDIT, btn_sel SHALL advance edit_dig by 1, wrapping NDIG-1 -> 0; when NDIG=1, edit_dig SHALL stay 0.
REQ-023 When btn_sel and btn_up/btn_dn coincide, the up/down SHALL apply to the old digit, then edit_dig SHALL advance.
REQ-024 On commit in EDIT, max_val <= edit_val, max_upd SHALL pulse and the FSM SHALL go to LOCK.
REQ-025 Commit SHALL have priority over btn_sel/up/dn in the same cycle; those buttons are ignored and the pre-edge edit_val is committed.
REQ-026 In EDIT, EN_set=0 or EN_work=0 SHALL return the FSM to IDLE with max_val unchanged and no max_upd, discarding edits; this SHALL override a simultaneous commit.
REQ-027 LOCK -> IDLE SHALL occur when EN_set=0 or EN_work=0; LOCK prevents immediate re-entry to EDIT while EN_set is held.
REQ-028 In EDIT and LOCK, load_n SHALL be ignored; in LOCK, all buttons SHALL be ignored.
REQ-029 max_val and edit_val SHALL hold valid BCD in every digit at all times.
REQ-030 max_upd SHALL be 0 in every cycle not covered by REQ-018 or REQ-024.

Reset
REQ-031 On RST_n=0, immediately and without a clock, max_val and edit_val SHALL go to DEF_MAX; edit_dig, editing and max_upd SHALL go to 0; the FSM SHALL go to IDLE.
REQ-032 Reset asserted mid-edit SHALL discard the edit; operation SHALL resume on the first CLK edge after RST_n rises.

Verification (NDIG=2, DEF_MAX=8'h99 unless stated)
REQ-033 Reset: assert RST_n=0 between clock edges -> max_val=8'h99, editing=0, max_upd=0 with no clock edge.
REQ-034 Direct load: IDLE, EN_work=1, EN_set=0, load_n=0, set_val=8'hA3 -> next edge max_val=8'h93, max_upd=1 for exactly one cycle.
REQ-035 Edit flow: EN_set=1, then btn_up (digit0 9->0), btn_sel, btn_dn (digit1 9->8), commit -> max_val=8'h80, max_upd=1 for one cycle, editing=0; holding EN_set stays in LOCK; dropping EN_set -> IDLE.
REQ-036 Abort: in EDIT, change edit_val to 8'h55, then EN_work=0 in the same cycle as commit -> IDLE, max_val remains 8'h99, max_upd stays 0.
REQ-037 Boundaries: up and dn together -> no change; NDIG=3 with three btn_sel pulses -> edit_dig 0->1->2->0; btn_dn on digit value 0 -> 9.
REQ-038 Priority: commit together with btn_up on edit_val=8'h42 -> max_val=8'h42, not 8'h43.
